// File: rtl/lvmb_adc_reader.sv
// Serial master for the seven LVMB ADCs: sends a control byte and reads back a 12-bit result.
// Optional macro LVMB_ADC_SCAN_EN enables an eight-channel scan per request.
module lvmb_adc_reader #(
  parameter int CLK_DIV   = 4,
  parameter int CONV_WAIT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  adc_sel,
  input  logic [2:0]  chan,
  input  logic        rng,
  input  logic        bip,
  input  logic        scan,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] data,
  output logic [2:0]  chan_out,
  output logic [6:0]  adc_ce,
  output logic        adc_sclk,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT_CTRL, CONV, SHIFT_DATA, CS_HOLD, DONE
  } state_t;

  localparam logic [15:0] DIV     = 16'(CLK_DIV);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] PER_M1  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] CONV_M1 = 16'(CONV_WAIT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [2:0]  sel_r;
  logic [2:0]  chan_r;
  logic        rng_r;
  logic        bip_r;
  logic        scan_r;
  logic [7:0]  ctrl_sh;
  logic [11:0] rx_sh;
  logic [7:0]  ctrl_word;

  function automatic logic [6:0] ce_for(input logic [2:0] s);
    logic [6:0] one;
    one    = 7'd1;
    ce_for = ~(one << s);
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic [2:0] c, input logic r, input logic b);
    ctrl_byte = {1'b1, c, r, b, 1'b0, 1'b1};
  endfunction

  assign ctrl_word = ctrl_byte(chan_r, rng_r, bip_r);

`ifndef LVMB_ADC_SCAN_EN
  logic unused_scan;
  assign unused_scan = scan;
`endif

  // Transaction sequencer; every pin and status output is registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      bit_cnt  <= 4'd0;
      sel_r    <= 3'd0;
      chan_r   <= 3'd0;
      rng_r    <= 1'b0;
      bip_r    <= 1'b0;
      scan_r   <= 1'b0;
      ctrl_sh  <= 8'd0;
      rx_sh    <= 12'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data     <= 12'd0;
      chan_out <= 3'd0;
      adc_ce   <= 7'h7F;
      adc_sclk <= 1'b0;
      adc_sdi  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_r <= adc_sel;
            rng_r <= rng;
            bip_r <= bip;
`ifdef LVMB_ADC_SCAN_EN
            scan_r <= scan;
            chan_r <= scan ? 3'd0 : chan;
`else
            scan_r <= 1'b0;
            chan_r <= chan;
`endif
            cnt <= 16'd0;
            if (adc_sel == 3'd7) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              adc_ce <= ce_for(adc_sel);
              busy   <= 1'b1;
              state  <= CS_SETUP;
            end
          end
        end
        CS_SETUP: begin
          if (cnt == HALF_M1) begin
            cnt     <= 16'd0;
            bit_cnt <= 4'd0;
            adc_sdi <= ctrl_word[7];
            ctrl_sh <= {ctrl_word[6:0], 1'b0};
            state   <= SHIFT_CTRL;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT_CTRL: begin
          if (cnt == HALF_M1) adc_sclk <= 1'b1;
          if (cnt == PER_M1) begin
            adc_sclk <= 1'b0;
            cnt      <= 16'd0;
            if (bit_cnt == 4'd7) begin
              adc_sdi <= 1'b0;
              state   <= CONV;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              adc_sdi <= ctrl_sh[7];
              ctrl_sh <= {ctrl_sh[6:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CONV: begin
          if (cnt == CONV_M1) begin
            cnt     <= 16'd0;
            bit_cnt <= 4'd0;
            state   <= SHIFT_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT_DATA: begin
          if (cnt == HALF_M1) adc_sclk <= 1'b1;
          if (cnt == PER_M1) begin
            adc_sclk <= 1'b0;
            cnt      <= 16'd0;
            if (bit_cnt < 4'd12) rx_sh <= {rx_sh[10:0], adc_sdo};
            if (bit_cnt == 4'd15) state <= CS_HOLD;
            else bit_cnt <= bit_cnt + 4'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CS_HOLD: begin
          // First cycle lets SCLK settle low so CE never moves under a high clock.
          adc_ce <= 7'h7F;
          if (cnt == DIV) begin
            done     <= 1'b1;
            data     <= rx_sh;
            chan_out <= chan_r;
            state    <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          cnt <= 16'd0;
          if (scan_r && (chan_r != 3'd7) && (sel_r != 3'd7)) begin
            chan_r <= chan_r + 3'd1;
            adc_ce <= ce_for(sel_r);
            state  <= CS_SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lvmb_adc_reader.md
# lvmb_adc_reader

Serial-interface master for the seven LVMB voltage/current ADCs. It receives a conversion request for one ADC and one channel and drives the active-low chip-enables, serial clock and serial data-in. It then captures the 12-bit result from the single muxed SDO line that the downstream SDO multiplexer returns. It sits between the VME/ODMB register logic that issues requests and the LVMB ADC pins/SDO mux, and its `adc_ce` output is the select that the SDO mux decodes.

## Interface
Parameters:
- `CLK_DIV`, 4: half-period of `adc_sclk` in `clk` cycles; minimum 1.
- `CONV_WAIT`, 64: `clk` cycles that CE stays low with SCLK idle between control byte and data readout.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `adc_sel`  in  3  target ADC 0..6; 7 is illegal.
- `chan`  in  3  ADC input channel 0..7.
- `rng`  in  1  range bit of control byte.
- `bip`  in  1  bipolar bit of control byte.
- `scan`  in  1  scan request (see Configuration).
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` pulses.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for illegal `adc_sel`.
- `data`  out  12  last conversion result; holds between updates.
- `chan_out`  out  3  channel that `data` belongs to.
- `adc_ce`  out  7  active-low chip-enables; bit n selects ADC n.
- `adc_sclk`  out  1  serial clock; idles low.
- `adc_sdi`  out  1  serial data to the ADCs.
- `adc_sdo`  in  1  muxed serial data from the SDO mux.

## Operation
- Reset values: `adc_ce`=7'b1111111, `adc_sclk`=0, `adc_sdi`=0, `busy`=0, `done`=0, `err`=0, `data`=0, `chan_out`=0, state IDLE.
- Control byte, MSB first: {1, chan[2:0], rng, bip, 0, 1}.
- FSM states: IDLE, CS_SETUP, SHIFT_CTRL, CONV, SHIFT_DATA, CS_HOLD, DONE.
  - IDLE: on `start`=1, latch `adc_sel`, `chan`, `rng`, `bip` and `scan`. If `adc_sel`=7, go to DONE with `err` set, leaving CE and `data` untouched. Otherwise, go to CS_SETUP.
  - CS_SETUP: selected CE bit is low; wait `CLK_DIV` cycles.
  - SHIFT_CTRL: 8 SCLK periods.
  - CONV: `CONV_WAIT` cycles; SCLK low, SDI low.
  - SHIFT_DATA: 16 SCLK periods.
  - CS_HOLD: all CE bits high; wait `CLK_DIV` cycles.
  - DONE: for one cycle, pulse `done` and update `data`/`chan_out`, then return to IDLE.
- SCLK period: `CLK_DIV` cycles low, then `CLK_DIV` cycles high.
- SDI changes only at the start of a low half.
- `adc_sdo` is sampled on the last `clk` cycle of each high half.
- Data: the bits sampled on SCLK periods 1..12 form `data[11:0]`, MSB first. Periods 13..16 are clocked but discarded.
- `start` while `busy` is ignored and is not queued.
- Only one CE bit is ever low at a time. CE never changes while `adc_sclk`=1.
- Reset mid-transaction: on the next edge all outputs take their reset values. No `done` pulse is produced.

## Timing
- An accepted start at edge T drives the CE low and `busy`=1 at T+1.
- `done` pulses at T+2+50·`CLK_DIV`+`CONV_WAIT`. With defaults this is T+266.
- `data` is valid in the same cycle as `done` and holds afterwards.
- Illegal `adc_sel`: `done`=`err`=1 at T+1; `busy` is never raised.
- `start` is accepted again in the cycle after `done`, which is the IDLE cycle.

## Configuration
- `LVMB_ADC_SCAN_EN` defined:
  - A start with `scan`=1 converts channels 0..7 of the selected ADC back to back, and the `chan` input is ignored.
  - Each conversion is a full CS_SETUP..CS_HOLD sequence.
  - `done` pulses after each conversion, with `chan_out` = that channel.
  - `busy` stays high from acceptance through the eighth `done`. After each of the first seven `done` pulses, the FSM returns to CS_SETUP instead of IDLE.
- `LVMB_ADC_SCAN_EN` undefined: the `scan` port exists but is ignored, and every start performs a single conversion.

## Test plan
- Single conversion, `adc_sel`=2, `chan`=5, `rng`=`bip`=0, ADC model returns 0xA5C:
  - `adc_ce`=7'b1111011 throughout, and the SDI stream is 1,1,0,1,0,0,0,1.
  - `done` at T+266 with `data`=0xA5C, `chan_out`=5, `err`=0.
- Illegal select, `adc_sel`=7: `done`=`err`=1 at T+1; `adc_ce` stays 7'b1111111; `data` is unchanged.
- `start` re-pulsed at T+50 during a conversion: ignored; exactly one `done`.
- `rstn`=0 for one cycle during SHIFT_DATA:
  - Next cycle `adc_ce`=7'b1111111, `adc_sclk`=0, `busy`=0, and no `done`.
  - A fresh start then completes normally.
- Protocol checker across 100 random requests:
  - SCLK high/low = `CLK_DIV` each.
  - Never more than one CE low.
  - CE stable while SCLK=1.
- With `LVMB_ADC_SCAN_EN`, `scan`=1, `adc_sel`=6, model returns 0x100+channel:
  - Eight `done` pulses with `chan_out`=0..7 and `data`=0x100..0x107.
  - `busy` is continuous until the eighth `done`.
